axis_fifo_pkt: RTL and testbench

Parametrised next-generation AXI4-Stream FIFO with full tready backpressure on the slave side, full-width tkeep and true depth-N full detection. An optional packet mode holds m_axis_tvalid low until a complete tlast-terminated packet is stored, and drops any packet that cannot fit. It sits between stream producers and consumers in the AXIS datapath and exports fill-level status for flow control.

---
 rtl/axis_fifo_pkt.sv | 135 +++++++++++++
 tb/tb_axis_fifo_pkt.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_pkt.sv
// AXI4-Stream FIFO with fall-through head, registered fill status and an optional
// store-and-forward packet mode that drops packets too large to fit in the FIFO.
module axis_fifo_pkt #(
  parameter int data_bits         = 32,
  parameter int tkeep_width       = data_bits / 8,
  parameter int addr_bits         = 4,
  parameter int packet_mode       = 0,
  parameter int almost_full_level = 12
) (
  input  logic                   axis_clk,
  input  logic                   axis_reset,
  input  logic [data_bits-1:0]   s_axis_tdata,
  input  logic [tkeep_width-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [data_bits-1:0]   m_axis_tdata,
  output logic [tkeep_width-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [addr_bits:0]     fill_level,
  output logic                   almost_full,
  output logic                   pkt_drop
);
  // Handshake: a beat moves on a port only in a cycle where valid and ready are both
  // high; s_axis_tready depends only on registered state, never on m_axis_tready.

  localparam int DEPTH = 2 ** addr_bits;
  localparam int EW    = data_bits + tkeep_width + 1;
  localparam logic [addr_bits:0] AF_LEVEL = (addr_bits + 1)'(almost_full_level);
  localparam logic [addr_bits:0] PTR_ONE  = (addr_bits + 1)'(1);
  localparam logic [addr_bits:0] FULL_XOR = {1'b1, {addr_bits{1'b0}}};
  localparam bit PKT = (packet_mode != 0);

  typedef enum logic {ST_PASS = 1'b0, ST_DROP = 1'b1} state_t;
  state_t state_q, state_d;

  logic [EW-1:0]      mem [DEPTH];
  logic [EW-1:0]      head;
  logic [addr_bits:0] wr_ptr_q, wr_ptr_d;
  logic [addr_bits:0] rd_ptr_q, rd_ptr_d;
  logic [addr_bits:0] pkt_start_q, pkt_start_d;
  logic [addr_bits:0] pkt_count_q, pkt_count_d;
  logic [addr_bits:0] fill_q, fill_d;
  logic               full_q, full_d;
  logic               af_q, af_d;
  logic               empty, head_valid, wr_en, rd_en, rewind, drop_pulse, tready_c;

  assign empty         = (wr_ptr_q == rd_ptr_q);
  assign head          = mem[rd_ptr_q[addr_bits-1:0]];
  assign head_valid    = !empty && (!PKT || (pkt_count_q != '0));
  assign rd_en         = head_valid && m_axis_tready;
  assign m_axis_tvalid = head_valid;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = head_valid ? head : '0;
  assign s_axis_tready = tready_c && !axis_reset;
  assign fill_level    = fill_q;
  assign almost_full   = af_q;
  assign pkt_drop      = drop_pulse;

  // A full FIFO with no complete packet means the packet being written cannot fit.
  always_comb begin
    state_d    = state_q;
    tready_c   = 1'b0;
    wr_en      = 1'b0;
    rewind     = 1'b0;
    drop_pulse = 1'b0;
    case (state_q)
      ST_PASS: begin
        tready_c = !full_q;
        wr_en    = s_axis_tvalid && !full_q && !axis_reset;
        if (PKT && full_q && (pkt_count_q == '0) && s_axis_tvalid) begin
          rewind = 1'b1;
          if (s_axis_tlast) drop_pulse = 1'b1;
          else              state_d    = ST_DROP;
        end
      end
      ST_DROP: begin
        tready_c = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          drop_pulse = 1'b1;
          state_d    = ST_PASS;
        end
      end
      default: state_d = ST_PASS;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pkt_start_d = pkt_start_q;
    pkt_count_d = pkt_count_q;
    if (rewind)     wr_ptr_d = pkt_start_q;
    else if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en)      rd_ptr_d = rd_ptr_q + PTR_ONE;
    // The next packet always begins right after the last committed tlast beat.
    if (wr_en && s_axis_tlast) pkt_start_d = wr_ptr_q + PTR_ONE;
    case ({wr_en && s_axis_tlast, rd_en && head[0]})
      2'b10:   pkt_count_d = pkt_count_q + PTR_ONE;
      2'b01:   pkt_count_d = pkt_count_q - PTR_ONE;
      default: pkt_count_d = pkt_count_q;
    endcase
    fill_d = wr_ptr_d - rd_ptr_d;
    full_d = ((wr_ptr_d ^ rd_ptr_d) == FULL_XOR);
    af_d   = (fill_d >= AF_LEVEL);
  end

  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q     <= ST_PASS;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_start_q <= '0;
      pkt_count_q <= '0;
      fill_q      <= '0;
      full_q      <= 1'b0;
      af_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_start_q <= pkt_start_d;
      pkt_count_q <= pkt_count_d;
      fill_q      <= fill_d;
      full_q      <= full_d;
      af_q        <= af_d;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (wr_en) mem[wr_ptr_q[addr_bits-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
  end

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// Bench for axis_fifo_pkt: one cut-through and one packet-mode instance, each checked
// every cycle against a queue-based model of stored beats and complete packets.
module tb_axis_fifo_pkt;
  localparam int DB = 32, KW = 4, AB = 4, DEPTH = 16, AFL = 12, EW = DB + KW + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [DB-1:0] ct_s_tdata, ct_m_tdata, pk_s_tdata, pk_m_tdata;
  logic [KW-1:0] ct_s_tkeep, ct_m_tkeep, pk_s_tkeep, pk_m_tkeep;
  logic          ct_s_tlast, ct_s_tvalid, ct_s_tready, ct_m_tlast, ct_m_tvalid, ct_m_tready;
  logic          pk_s_tlast, pk_s_tvalid, pk_s_tready, pk_m_tlast, pk_m_tvalid, pk_m_tready;
  logic [AB:0]   ct_fill, pk_fill;
  logic          ct_af, pk_af, ct_drop, pk_drop;

  axis_fifo_pkt #(.data_bits(DB), .addr_bits(AB), .packet_mode(0), .almost_full_level(AFL)) dut_ct (
    .axis_clk(clk), .axis_reset(rst),
    .s_axis_tdata(ct_s_tdata), .s_axis_tkeep(ct_s_tkeep), .s_axis_tlast(ct_s_tlast),
    .s_axis_tvalid(ct_s_tvalid), .s_axis_tready(ct_s_tready),
    .m_axis_tdata(ct_m_tdata), .m_axis_tkeep(ct_m_tkeep), .m_axis_tlast(ct_m_tlast),
    .m_axis_tvalid(ct_m_tvalid), .m_axis_tready(ct_m_tready),
    .fill_level(ct_fill), .almost_full(ct_af), .pkt_drop(ct_drop));

  axis_fifo_pkt #(.data_bits(DB), .addr_bits(AB), .packet_mode(1), .almost_full_level(AFL)) dut_pk (
    .axis_clk(clk), .axis_reset(rst),
    .s_axis_tdata(pk_s_tdata), .s_axis_tkeep(pk_s_tkeep), .s_axis_tlast(pk_s_tlast),
    .s_axis_tvalid(pk_s_tvalid), .s_axis_tready(pk_s_tready),
    .m_axis_tdata(pk_m_tdata), .m_axis_tkeep(pk_m_tkeep), .m_axis_tlast(pk_m_tlast),
    .m_axis_tvalid(pk_m_tvalid), .m_axis_tready(pk_m_tready),
    .fill_level(pk_fill), .almost_full(pk_af), .pkt_drop(pk_drop));

  // Reference model: stored beats in order, count of complete packets, beats of the
  // packet still being written, and whether an oversize packet is being discarded.
  logic [EW-1:0] ct_m[$];
  logic [EW-1:0] pk_m[$];
  int  pk_done = 0, pk_part = 0;
  bit  pk_dropping = 1'b0;
  bit  ct_acc, pk_acc;
  int  ct_hs = 0, pk_hs = 0, pk_vcyc = 0, pk_drops = 0;
  int  n_assert = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    ct_m.delete();
    pk_m.delete();
    pk_done = 0;
    pk_part = 0;
    pk_dropping = 1'b0;
  endtask

  task automatic tick();
    logic [EW-1:0] ct_head_e, pk_head_e, pk_beat;
    bit ct_rdy_e, ct_val_e, pk_rdy_e, pk_val_e, pk_ovf, pk_drop_e, ct_rd, pk_rd, pk_last;
    #1;
    ct_rdy_e  = ct_m.size() < DEPTH;
    ct_val_e  = ct_m.size() != 0;
    ct_head_e = ct_val_e ? ct_m[0] : '0;
    check("ct_tready", ct_s_tready, ct_rdy_e);
    check("ct_tvalid", ct_m_tvalid, ct_val_e);
    check("ct_head", {ct_m_tdata, ct_m_tkeep, ct_m_tlast}, ct_head_e);
    check("ct_fill", ct_fill, ct_m.size());
    check("ct_almost_full", ct_af, ct_m.size() >= AFL);
    check("ct_pkt_drop", ct_drop, 1'b0);
    pk_rdy_e  = pk_dropping || (pk_m.size() < DEPTH);
    pk_val_e  = (pk_m.size() != 0) && (pk_done != 0);
    pk_head_e = pk_val_e ? pk_m[0] : '0;
    pk_ovf    = !pk_dropping && (pk_m.size() == DEPTH) && (pk_done == 0) && pk_s_tvalid;
    pk_drop_e = pk_ovf ? pk_s_tlast : (pk_dropping && pk_s_tvalid && pk_s_tlast);
    check("pk_tready", pk_s_tready, pk_rdy_e);
    check("pk_tvalid", pk_m_tvalid, pk_val_e);
    check("pk_head", {pk_m_tdata, pk_m_tkeep, pk_m_tlast}, pk_head_e);
    check("pk_fill", pk_fill, pk_m.size());
    check("pk_almost_full", pk_af, pk_m.size() >= AFL);
    check("pk_pkt_drop", pk_drop, pk_drop_e);
    ct_acc  = ct_s_tvalid && ct_rdy_e;
    pk_acc  = pk_s_tvalid && pk_rdy_e;
    ct_rd   = ct_val_e && ct_m_tready;
    pk_rd   = pk_val_e && pk_m_tready;
    pk_beat = {pk_s_tdata, pk_s_tkeep, pk_s_tlast};
    pk_last = pk_s_tlast;
    if (ct_m_tvalid && ct_m_tready) ct_hs++;
    if (pk_m_tvalid && pk_m_tready) pk_hs++;
    if (pk_m_tvalid) pk_vcyc++;
    if (pk_drop) pk_drops++;
    @(posedge clk);
    if (ct_rd) void'(ct_m.pop_front());
    if (ct_acc) ct_m.push_back({ct_s_tdata, ct_s_tkeep, ct_s_tlast});
    if (pk_rd) begin
      if (pk_m[0][0]) pk_done--;
      void'(pk_m.pop_front());
    end
    if (pk_ovf) begin
      repeat (pk_part) void'(pk_m.pop_back());
      pk_part = 0;
      pk_dropping = !pk_last;
    end else if (pk_dropping) begin
      if (pk_acc && pk_last) pk_dropping = 1'b0;
    end else if (pk_acc) begin
      pk_m.push_back(pk_beat);
      if (pk_last) begin pk_done++; pk_part = 0; end
      else pk_part++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_ct_tready", ct_s_tready, 1'b0);
    check("rst_pk_tready", pk_s_tready, 1'b0);
    check("rst_ct_tvalid", ct_m_tvalid, 1'b0);
    check("rst_pk_tvalid", pk_m_tvalid, 1'b0);
    check("rst_ct_fill", ct_fill, 0);
    check("rst_pk_fill", pk_fill, 0);
    check("rst_ct_af", ct_af, 1'b0);
    check("rst_pk_drop", pk_drop, 1'b0);
    clear_model();
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_ct_tready", ct_s_tready, 1'b0);
    check("rst_hold_pk_tvalid", pk_m_tvalid, 1'b0);
    rst = 1'b0;
  endtask

  task automatic pk_send(input int len, input bit rand_rdy, input bit gaps);
    int guard;
    for (int b = 0; b < len; b++) begin
      if (gaps) begin
        pk_s_tvalid = 1'b0;
        repeat ($urandom_range(0, 1)) begin
          if (rand_rdy) pk_m_tready = 1'($urandom_range(0, 1));
          tick();
        end
      end
      pk_s_tvalid = 1'b1;
      pk_s_tdata  = $urandom;
      pk_s_tkeep  = 4'($urandom_range(1, 15));
      pk_s_tlast  = (b == len - 1);
      guard = 0;
      do begin
        if (rand_rdy) pk_m_tready = 1'($urandom_range(0, 1));
        tick();
        guard++;
      end while (!pk_acc && guard < 100);
      if (!pk_acc) check("pk_send_timeout", guard, 0);
    end
    pk_s_tvalid = 1'b0;
    pk_s_tlast  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ct_s_tdata = '0; ct_s_tkeep = '0; ct_s_tlast = 1'b0; ct_s_tvalid = 1'b0; ct_m_tready = 1'b0;
    pk_s_tdata = '0; pk_s_tkeep = '0; pk_s_tlast = 1'b0; pk_s_tvalid = 1'b0; pk_m_tready = 1'b0;
    @(negedge clk);
    do_reset();
    tick();

    // Mid-stream reset: stored beats and a partial packet must never reappear.
    for (int i = 0; i < 5; i++) begin
      ct_s_tvalid = 1'b1; ct_s_tdata = 32'hA000_0000 + i; ct_s_tkeep = 4'hF; ct_s_tlast = (i == 4);
      tick();
    end
    ct_s_tvalid = 1'b0;
    pk_send(2, 1'b0, 1'b0);
    pk_s_tvalid = 1'b1; pk_s_tdata = 32'hBEEF; pk_s_tkeep = 4'hF; pk_s_tlast = 1'b0;
    tick();
    pk_s_tvalid = 1'b0;
    do_reset();
    ct_m_tready = 1'b1; pk_m_tready = 1'b1;
    repeat (3) tick();

    // Cut-through fill to depth with the consumer stalled, then drain in order.
    ct_m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ct_s_tvalid = 1'b1; ct_s_tdata = i; ct_s_tkeep = 4'hF; ct_s_tlast = (i == 15);
      tick();
    end
    ct_s_tdata = 32'h10; ct_s_tlast = 1'b0;
    repeat (2) tick();
    check("ct_full_fill", ct_fill, 16);
    check("ct_full_af", ct_af, 1'b1);
    ct_s_tvalid = 1'b0;
    ct_m_tready = 1'b1;
    repeat (17) tick();

    // Cut-through full rate across pointer wrap: one beat per cycle, no bubbles.
    ct_hs = 0;
    for (int i = 0; i < 100; i++) begin
      ct_s_tvalid = 1'b1; ct_s_tdata = $urandom; ct_s_tkeep = 4'($urandom); ct_s_tlast = 1'($urandom);
      tick();
      if (i > 0) check("ct_rate_fill", ct_fill, 1);
    end
    ct_s_tvalid = 1'b0;
    tick();
    check("ct_rate_reads", ct_hs, 100);

    // Cut-through random traffic with random backpressure on both sides.
    for (int i = 0; i < 300; i++) begin
      if (!ct_s_tvalid || ct_acc) begin
        ct_s_tvalid = ($urandom_range(0, 3) != 0);
        ct_s_tdata = $urandom; ct_s_tkeep = 4'($urandom); ct_s_tlast = 1'($urandom);
      end
      ct_m_tready = ($urandom_range(0, 2) == 0);
      tick();
    end
    ct_s_tvalid = 1'b0; ct_m_tready = 1'b1;
    repeat (18) tick();

    // Packet mode: a 4-beat packet is held back until its tlast beat is stored.
    pk_m_tready = 1'b1;
    pk_hs = 0;
    pk_send(4, 1'b0, 1'b0);
    check("pk4_no_early_read", pk_hs, 0);
    repeat (6) tick();
    check("pk4_reads", pk_hs, 4);

    // Packet mode: a 20-beat packet cannot fit and is dropped once; a 3-beat one follows.
    pk_vcyc = 0; pk_drops = 0;
    pk_send(20, 1'b0, 1'b0);
    tick();
    check("pk20_drops", pk_drops, 1);
    check("pk20_fill", pk_fill, 0);
    check("pk20_never_valid", pk_vcyc, 0);
    pk_hs = 0;
    pk_send(3, 1'b0, 1'b0);
    repeat (5) tick();
    check("pk3_reads", pk_hs, 3);

    // Packet mode: tlast read and tlast write in the same cycle, output without gaps.
    pk_m_tready = 1'b0;
    pk_send(2, 1'b0, 1'b0);
    pk_send(2, 1'b0, 1'b0);
    pk_m_tready = 1'b1;
    pk_hs = 0;
    pk_send(2, 1'b0, 1'b0);
    repeat (4) tick();
    check("pk_no_gap_reads", pk_hs, 6);
    repeat (2) tick();

    // Packet mode random traffic, including occasional oversize packets.
    for (int p = 0; p < 40; p++) begin
      pk_send(($urandom_range(0, 9) == 0) ? 18 : $urandom_range(1, 6), 1'b1, 1'b1);
    end
    pk_m_tready = 1'b1;
    repeat (20) tick();
    check("pk_final_fill", pk_fill, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
